// File: rtl/alarm_ctrl_fsm_pkg.sv
// Shared alarm-clock definitions: FSM state codes, key codes
// and control bundle, reused by keypad scanner and benches.
package alarm_clock_defs;

  localparam int         TIMEOUT_SEC_DEF = 10;
  localparam int         CNT_W           = 4;
  localparam logic [3:0] NOKEY           = 4'd10;
  localparam logic [3:0] KEY_MAX         = 4'd9;

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    KEY_STORED = 3'd1,
    KEY_WAITED = 3'd2,
    KEY_ENTRY  = 3'd3,
    SHOW_ALARM = 3'd4
  } state_t;

  typedef struct packed {
    logic shift;
    logic load_new_a;
    logic load_new_c;
    logic reset_count;
    logic show_a;
    logic show_current_time;
  } ctrl_t;

  function automatic logic key_is_digit(
    input logic [3:0] k
  );
    return k <= KEY_MAX;
  endfunction

  function automatic logic is_entry_state(
    input state_t s
  );
    return (s == KEY_STORED) ||
           (s == KEY_WAITED) ||
           (s == KEY_ENTRY);
  endfunction

endpackage

// File: rtl/alarm_ctrl_fsm_timeout_cnt.sv
// Clearable one-second tick counter that saturates on its
// last count and flags the tick that lands on it.
import alarm_clock_defs::*;

module alarm_timeout_cnt #(
  parameter int LIMIT = TIMEOUT_SEC_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last    = (r_cnt == LAST);
  assign o_timeout = w_last && i_tick;

  // Holding at LAST keeps the timeout armed for the next tick.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_ctrl_fsm.sv
// Alarm clock control FSM: keypad entry, alarm/time loading
// and LCD display selection, all outputs registered.
import alarm_clock_defs::*;

module alarm_ctrl_fsm #(
  parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       reset_count,
  output logic       show_a,
  output logic       show_current_time
);

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  ctrl_t  w_ctrl;
  logic   w_key_valid;
  logic   w_timeout;
  logic   w_load_a;
  logic   w_load_c;
  logic   w_cnt_clr;
  logic   w_cnt_tick;

  assign w_key_valid = key_is_digit(key);
  assign w_cnt_clr   = (w_next == KEY_STORED);
  assign w_cnt_tick  = one_second &&
                       ((r_state == KEY_WAITED) ||
                        (r_state == KEY_ENTRY));

  alarm_timeout_cnt #(
    .LIMIT (TIMEOUT_SEC)
  ) u_tmo (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clr     (w_cnt_clr),
    .i_tick    (w_cnt_tick),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= SHOW_TIME;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_ctrl;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_load_a = 1'b0;
    w_load_c = 1'b0;
    case (r_state)
      SHOW_TIME: begin
        if (alarm_button) begin
          w_next = SHOW_ALARM;
        end else if (w_key_valid) begin
          w_next = KEY_STORED;
        end
      end
      KEY_STORED: begin
        w_next = KEY_WAITED;
      end
      KEY_WAITED: begin
        if (!w_key_valid) begin
          w_next = KEY_ENTRY;
        end else if (w_timeout) begin
          w_next = SHOW_TIME;
        end
      end
      KEY_ENTRY: begin
        if (alarm_button) begin
          w_next   = SHOW_TIME;
          w_load_a = 1'b1;
        end else if (time_button) begin
          w_next   = SHOW_TIME;
          w_load_c = 1'b1;
        end else if (w_key_valid) begin
          w_next = KEY_STORED;
        end else if (w_timeout) begin
          w_next = SHOW_TIME;
        end
      end
      SHOW_ALARM: begin
        if (!alarm_button) begin
          w_next = SHOW_TIME;
        end
      end
      default: begin
        w_next = SHOW_TIME;
      end
    endcase
  end

  // KEY_STORED lasts one cycle, so shift is a single pulse.
  always_comb begin
    w_ctrl                   = '0;
    w_ctrl.shift             = (w_next == KEY_STORED);
    w_ctrl.load_new_a        = w_load_a;
    w_ctrl.load_new_c        = w_load_c;
    w_ctrl.reset_count       = w_load_c;
    w_ctrl.show_a            = (w_next == SHOW_ALARM);
    w_ctrl.show_current_time = is_entry_state(w_next);
  end

  assign shift             = r_ctrl.shift;
  assign load_new_a        = r_ctrl.load_new_a;
  assign load_new_c        = r_ctrl.load_new_c;
  assign reset_count       = r_ctrl.reset_count;
  assign show_a            = r_ctrl.show_a;
  assign show_current_time = r_ctrl.show_current_time;

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Bench for alarm_ctrl_fsm: behavioural model compared every
// cycle plus directed scenarios with literal expectations.
module tb_alarm_ctrl_fsm;

  localparam int         T  = 10;
  localparam logic [3:0] NK = 4'd10;
  localparam int V_CLOCK = 0;
  localparam int V_ALARM = 1;
  localparam int V_ENTRY = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key = NK;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       shift, load_new_a, load_new_c, reset_count;
  logic       show_a, show_current_time;

  int checks = 0;
  int errors = 0;

  alarm_ctrl_fsm #(
    .TIMEOUT_SEC (T)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .one_second        (one_second),
    .key               (key),
    .alarm_button      (alarm_button),
    .time_button       (time_button),
    .shift             (shift),
    .load_new_a        (load_new_a),
    .load_new_c        (load_new_c),
    .reset_count       (reset_count),
    .show_a            (show_a),
    .show_current_time (show_current_time)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the user is doing, not FSM states.
  int m_view = V_CLOCK;
  bit m_stored = 0;
  bit m_wait = 0;
  int m_ticks = 0;
  bit m_ready = 0;
  bit e_sh, e_la, e_lc, e_rc, e_sa, e_sct;

  always @(posedge clock) begin
    bit kv;
    bit tk;
    kv = (key <= 4'd9);
    tk = one_second;
    e_sh = 0; e_la = 0; e_lc = 0; e_rc = 0;
    if (!reset_n) begin
      m_view = V_CLOCK; m_stored = 0; m_wait = 0;
      m_ticks = 0; m_ready = 1;
    end else if (m_view == V_CLOCK) begin
      if (alarm_button) m_view = V_ALARM;
      else if (kv) begin
        m_view = V_ENTRY; m_stored = 1; e_sh = 1; m_ticks = 0;
      end
    end else if (m_view == V_ALARM) begin
      if (!alarm_button) m_view = V_CLOCK;
    end else if (m_stored) begin
      m_stored = 0; m_wait = 1;
    end else if (m_wait) begin
      if (!kv) m_wait = 0;
      else if (tk && m_ticks >= T - 1) begin
        m_view = V_CLOCK; m_wait = 0;
      end
      if (m_view == V_ENTRY) m_ticks = m_ticks + int'(tk);
    end else begin
      if (alarm_button) begin
        m_view = V_CLOCK; e_la = 1;
      end else if (time_button) begin
        m_view = V_CLOCK; e_lc = 1; e_rc = 1;
      end else if (kv) begin
        m_stored = 1; e_sh = 1; m_ticks = 0;
      end else if (tk && m_ticks >= T - 1) begin
        m_view = V_CLOCK;
      end else begin
        m_ticks = m_ticks + int'(tk);
      end
    end
    if (m_ticks > T - 1) m_ticks = T - 1;
    e_sa  = (m_view == V_ALARM);
    e_sct = (m_view == V_ENTRY);
  end

  int n_sh = 0, n_la = 0, n_lc = 0, n_rc = 0, n_sa = 0;

  always @(negedge clock) begin
    if (m_ready) begin
      chk("shift", int'(shift), int'(e_sh));
      chk("load_new_a", int'(load_new_a), int'(e_la));
      chk("load_new_c", int'(load_new_c), int'(e_lc));
      chk("reset_count", int'(reset_count), int'(e_rc));
      chk("show_a", int'(show_a), int'(e_sa));
      chk("show_current_time", int'(show_current_time), int'(e_sct));
      if (show_a && show_current_time) chk("show_excl", 1, 0);
      n_sh += int'(shift);
      n_la += int'(load_new_a);
      n_lc += int'(load_new_c);
      n_rc += int'(reset_count);
      n_sa += int'(show_a);
    end
  end

  int b_sh, b_la, b_lc, b_rc, b_sa;

  task automatic snap();
    b_sh = n_sh; b_la = n_la; b_lc = n_lc; b_rc = n_rc; b_sa = n_sa;
  endtask

  task automatic step(input logic [3:0] k, input logic a,
                      input logic t, input logic s);
    @(negedge clock);
    key = k; alarm_button = a; time_button = t; one_second = s;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 0; key = NK; alarm_button = 0;
    time_button = 0; one_second = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
  endtask

  task automatic digit(input logic [3:0] k);
    step(k, 0, 0, 0);
    step(NK, 0, 0, 0);
    step(NK, 0, 0, 0);
  endtask

  task automatic tick_pair();
    step(NK, 0, 0, 1);
    step(NK, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    settle();
    chk("reset_outs", int'({shift, load_new_a, load_new_c,
        reset_count, show_a, show_current_time}), 0);

    // single held key
    snap();
    step(4'd3, 0, 0, 0);
    after_edge();
    chk("held_shift_first", int'(shift), 1);
    chk("held_sct_first", int'(show_current_time), 1);
    repeat (4) step(4'd3, 0, 0, 0);
    step(NK, 0, 0, 0);
    step(NK, 0, 0, 0);
    settle();
    chk("held_shift_count", n_sh - b_sh, 1);
    chk("held_sct_entry", int'(show_current_time), 1);

    // reset mid-entry with alarm pressed
    snap();
    @(negedge clock);
    reset_n = 0; alarm_button = 1;
    after_edge();
    chk("rst_outs_1", int'({shift, load_new_a, load_new_c,
        reset_count, show_a, show_current_time}), 0);
    after_edge();
    chk("rst_outs_2", int'({shift, load_new_a, load_new_c,
        reset_count, show_a, show_current_time}), 0);
    @(negedge clock);
    reset_n = 1; alarm_button = 0;
    after_edge();
    chk("rst_sct", int'(show_current_time), 0);
    settle();
    chk("rst_no_load", n_la + n_lc - b_la - b_lc, 0);

    // four digits then alarm load
    do_reset();
    snap();
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd0);
    step(NK, 1, 0, 0);
    after_edge();
    chk("alarm_load_a", int'(load_new_a), 1);
    chk("alarm_sct_drop", int'(show_current_time), 0);
    step(NK, 0, 0, 0);
    settle();
    chk("alarm_shift_count", n_sh - b_sh, 4);
    chk("alarm_load_count", n_la - b_la, 1);

    // alarm beats time
    do_reset();
    snap();
    digit(4'd7); digit(4'd8);
    step(NK, 1, 1, 0);
    step(NK, 0, 0, 0);
    settle();
    chk("prio_load_a", n_la - b_la, 1);
    chk("prio_load_c", n_lc - b_lc, 0);
    chk("prio_reset_count", n_rc - b_rc, 0);

    // time button load
    do_reset();
    snap();
    digit(4'd9);
    step(NK, 0, 1, 0);
    after_edge();
    chk("time_load_c", int'(load_new_c), 1);
    chk("time_reset_count", int'(reset_count), 1);
    step(NK, 0, 0, 0);
    settle();
    chk("time_load_count", n_lc - b_lc, 1);

    // timeout on tenth tick
    do_reset();
    snap();
    digit(4'd4);
    repeat (T - 1) tick_pair();
    settle();
    chk("tmo_sct_9", int'(show_current_time), 1);
    step(NK, 0, 0, 1);
    after_edge();
    chk("tmo_sct_10", int'(show_current_time), 0);
    step(NK, 0, 0, 0);
    settle();
    chk("tmo_no_load", n_la + n_lc - b_la - b_lc, 0);

    // key on the ninth tick restarts the count
    do_reset();
    snap();
    digit(4'd4);
    repeat (T - 2) tick_pair();
    step(4'd6, 0, 0, 1);
    after_edge();
    chk("tick_key_shift", int'(shift), 1);
    step(NK, 0, 0, 0);
    step(NK, 0, 0, 0);
    repeat (T - 1) tick_pair();
    settle();
    chk("tick_key_sct", int'(show_current_time), 1);
    step(NK, 0, 0, 1);
    after_edge();
    chk("tick_key_tmo", int'(show_current_time), 0);

    // alarm view held with a digit on the keypad
    do_reset();
    snap();
    repeat (20) step(4'd5, 1, 0, 0);
    step(NK, 0, 0, 0);
    after_edge();
    chk("view_release", int'(show_a), 0);
    settle();
    chk("view_show_a_cycles", n_sa - b_sa, 20);
    chk("view_no_shift", n_sh - b_sh, 0);

    repeat (3) step(NK, 0, 0, 0);
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl_fsm.md
Name: alarm_ctrl_fsm

Overview:
- Control FSM for the alarm clock: sequences keypad entry, alarm/time loading and display mode selection.
- Drives show_a / show_current_time into the 4-digit LCD driver.
- Drives shift into the key register, load_new_a into the alarm register, and load_new_c / reset_count into the time counter.
- Aborts an idle key entry after TIMEOUT_SEC one-second ticks.

Parameters:
- TIMEOUT_SEC, 10, number of one_second ticks with no key activity before entry is abandoned; legal range 2..15.
- NOKEY, 4'd10, key code meaning "no key pressed"; codes 0..9 are digits, codes 11..15 are treated as NOKEY.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- one_second  input  1  one-cycle tick, once per second.
- key  input  4  keypad code, 0..9 or NOKEY.
- alarm_button  input  1  level, held while pressed.
- time_button  input  1  level.
- shift  output  1  one-cycle pulse: key register shifts in key.
- load_new_a  output  1  one-cycle pulse: alarm register loads key register.
- load_new_c  output  1  one-cycle pulse: time counter loads key register.
- reset_count  output  1  one-cycle pulse, coincident with load_new_c: clears seconds.
- show_a  output  1  LCD shows alarm time.
- show_current_time  output  1  LCD shows key register (entry in progress).

Behaviour:
- States (3-bit encoding): SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM.
- Reset (reset_n=0 at a clock edge): state=SHOW_TIME, timeout counter=0, all outputs 0. Reset wins over every other event, including mid-entry; no load pulse is issued.
- All outputs are registered and decoded from next_state/transition. They are valid in the cycle the state is entered, one clock after the sampled inputs.
- key_valid = (key <= 9).
- SHOW_TIME transitions:
  - alarm_button -> SHOW_ALARM (takes priority over key).
  - key_valid -> KEY_STORED.
  - otherwise stay.
- KEY_STORED: unconditional -> KEY_WAITED. shift=1 for exactly this one cycle.
- KEY_WAITED: waits for key release.
  - !key_valid -> KEY_ENTRY.
  - timeout -> SHOW_TIME.
  - otherwise stay. A held key never produces a second shift.
- KEY_ENTRY, in priority order:
  - alarm_button -> SHOW_TIME, load_new_a=1 for one cycle.
  - time_button -> SHOW_TIME, load_new_c=1 and reset_count=1 for one cycle.
  - key_valid -> KEY_STORED.
  - timeout -> SHOW_TIME with no load.
- SHOW_ALARM: !alarm_button -> SHOW_TIME; stay while held.
- show_a=1 exactly while in SHOW_ALARM. show_current_time=1 while in KEY_STORED, KEY_WAITED or KEY_ENTRY. The two are never both 1.
- Timeout counter:
  - Cleared on every entry to KEY_STORED.
  - Increments on one_second while in KEY_WAITED or KEY_ENTRY.
  - timeout = counter == TIMEOUT_SEC-1 && one_second.
  - Saturates: no wrap.
  - If one_second and key_valid arrive in the same cycle in KEY_ENTRY, the key wins and the counter clears.
- Illegal state encodings go to SHOW_TIME on the next clock.

Decomposition:
- Shared package alarm_clock_defs holds the state encodings, NOKEY and the TIMEOUT_SEC default, for reuse by the keypad scanner and testbench.
- One natural sub-module, alarm_timeout_cnt: the clearable, saturating tick counter with a timeout output.
- The FSM stays in the top module.

Test Plan:
- reset_n=0 for 2 cycles mid-entry (state KEY_ENTRY) -> next cycle state SHOW_TIME, all outputs 0, no load pulse.
- key=3 held 5 cycles, then NOKEY -> shift pulses once, 1 cycle after key seen; show_current_time=1 from that cycle on; state reaches KEY_ENTRY.
- Digits 1,2,3,0 entered, then alarm_button=1 -> exactly 4 shift pulses; load_new_a=1 for one cycle; show_current_time drops the same cycle.
- Digits entered, then time_button=1 together with alarm_button=1 -> load_new_a only (alarm priority); load_new_c=0 and reset_count=0.
- Digits entered, then 10 one_second ticks with no key -> SHOW_TIME on the 10th tick with no load. Variant: key_valid arrives on the 9th tick -> counter clears, no timeout.
- alarm_button held 20 cycles from SHOW_TIME while key=5 -> show_a=1 for 20 cycles, no shift. On release, show_a=0 the next cycle.
